btn_conditioner: RTL
====================

# btn_conditioner

Conditions a raw push-button input into a clean, debounced level plus single-cycle event pulses for the LED shifter logic. Output events are press, release, long-press and auto-repeat. The block sits between the board button pin and any downstream consumer that edge-detects a button. Downstream logic sees one transition per physical press, never contact bounce.

## Interface
- `DB_CYCLES`, 20: consecutive stable synchronized samples required to accept a level change; must be ≥ 2.
- `LONG_CYCLES`, 100: cycles in HELD before `long_pulse`; must be ≥ 2.
- `REPEAT_CYCLES`, 25: period of `repeat_pulse` after a long press; must be ≥ 2.
- `REPEAT_EN`, 1: 1 enables auto-repeat; 0 suppresses `repeat_pulse`.
- `CNT_W`, 24: counter width; must hold max(`DB_CYCLES`, `LONG_CYCLES`, `REPEAT_CYCLES`) − 1.
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_in`  in  1  raw, asynchronous, bouncy button pin (1 = pressed).
- `btn_level`  out  1  debounced button level.
- `press_pulse`  out  1  one-cycle pulse when the debounced level rises.
- `release_pulse`  out  1  one-cycle pulse when the debounced level falls.
- `long_pulse`  out  1  one-cycle pulse once per press after `LONG_CYCLES` held.
- `repeat_pulse`  out  1  one-cycle pulse every `REPEAT_CYCLES` after `long_pulse` while held.

## Operation
- `btn_in` passes through a 2-flop synchronizer. The synchronized output is `btn_s`.
- One counter `cnt` is shared by all states. The flag `long_done` is set on `long_pulse` and cleared on return to IDLE.
- **IDLE** (level 0): if `btn_s`=1, go to DB_PRESS with `cnt`=1.
- **DB_PRESS** (level 0):
  - If `btn_s`=0, go to IDLE with `cnt`=0.
  - Else if `cnt`=`DB_CYCLES`−1, go to HELD: `btn_level`←1, `press_pulse`, `cnt`=0.
  - Else increment `cnt`.
- **HELD** (level 1):
  - If `btn_s`=0, go to DB_RELEASE with `cnt`=1.
  - Else if `cnt`=`LONG_CYCLES`−1, go to REPEAT: `long_pulse`, `long_done`←1, `cnt`=0.
  - Else increment `cnt`.
- **REPEAT** (level 1):
  - If `btn_s`=0, go to DB_RELEASE with `cnt`=1.
  - Else if `cnt`=`REPEAT_CYCLES`−1, `cnt`=0 and `repeat_pulse` asserts when `REPEAT_EN`=1.
  - Else increment `cnt`.
- **DB_RELEASE** (level 1):
  - If `btn_s`=1, return to REPEAT if `long_done`, else HELD, with `cnt`=0. No `press_pulse` is issued.
  - Else if `cnt`=`DB_CYCLES`−1, go to IDLE: `btn_level`←0, `release_pulse`, `long_done`←0.
  - Else increment `cnt`.
- The four pulse outputs are mutually exclusive and never assert in the same cycle.

## Timing
- Reset value of every output is 0. Reset also forces state IDLE, `cnt`=0, `long_done`=0 and both synchronizer flops to 0. Reset acts immediately; it does not wait for a clock.
- All outputs are registered.
- Press latency: if `btn_in` is first sampled 1 at edge 1 and stays high, `btn_level` and `press_pulse` go high after edge `DB_CYCLES`+2 (edge 22 with defaults). Release latency is symmetric.
- `long_pulse` is issued `LONG_CYCLES` edges after entry to HELD. With defaults: after edge 122.
- `repeat_pulse` then follows every `REPEAT_CYCLES` edges. With defaults: after edges 147, 172, 197, ...
- Any single-sample disagreement in a DB_* state restarts the debounce window.
- Reset asserted mid-press: the block behaves as freshly reset. If the button is still held when reset deasserts, a new press is reported after `DB_CYCLES`+2 edges.

## Structure
- Shared package `btn_pkg`:
  - `state_t` enum: IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE, binary-encoded, 3 bits.
  - Default timing constants.
- Sub-module `sync_2ff`: a 2-flop synchronizer with asynchronous active-low reset, reused for other pin inputs.
- Sub-module `btn_conditioner`: the FSM, counter and output registers.

## Test plan
All scenarios use default parameters.
- **Reset mid-press:** `rst`=0 asynchronously while in HELD -> all outputs 0 before the next edge. After `rst`=1 with the button still held, `press_pulse` fires after edge 22.
- **Clean press:** `btn_in` 0→1 at edge 1, held for 40 cycles -> `btn_level`=1 and a 1-cycle `press_pulse` after edge 22. No other pulses occur.
- **Bounce rejection:** `btn_in` high for 19 cycles, low for 1, high for 19, then low -> no pulses and `btn_level` stays 0.
- **Long press and repeat:** hold for 200 cycles -> `long_pulse` after edge 122 and `repeat_pulse` after edges 147, 172 and 197. With `REPEAT_EN`=0, no `repeat_pulse` occurs.
- **Release with glitch:** after a press, drop `btn_in` for 10 cycles, raise for 1, then drop permanently -> no second `press_pulse`. Exactly one `release_pulse` and `btn_level`=0 are issued 22 edges after the final drop.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the button conditioner.
//   state_t      : conditioner FSM state, binary-encoded in 3 bits
//   *Def         : default cycle counts used as parameter defaults
package btn_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StDbPress   = 3'd1,
    StHeld      = 3'd2,
    StRepeat    = 3'd3,
    StDbRelease = 3'd4
  } state_t;

  localparam int unsigned DbCyclesDef     = 20;
  localparam int unsigned LongCyclesDef   = 100;
  localparam int unsigned RepeatCyclesDef = 25;
  localparam int unsigned CntWDef         = 24;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit pin.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears both flops
//   d_i    : asynchronous input
//   q_o    : synchronized output (two clk_i edges of latency)
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces a raw push-button and emits one-cycle press, release, long-press and
// auto-repeat events. All outputs are registered.
//   clk           : system clock, rising edge
//   rst           : asynchronous active-low reset
//   btn_in        : raw bouncy button pin (1 = pressed)
//   btn_level     : debounced level
//   press_pulse   : debounced level rose
//   release_pulse : debounced level fell
//   long_pulse    : button held LONG_CYCLES after the press was accepted
//   repeat_pulse  : every REPEAT_CYCLES after long_pulse while held (if REPEAT_EN)
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DbCyclesDef,
  parameter int unsigned LONG_CYCLES   = LongCyclesDef,
  parameter int unsigned REPEAT_CYCLES = RepeatCyclesDef,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned CNT_W         = CntWDef
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] DbLast     = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  logic btn_s;

  sync_2ff u_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (btn_in),
    .q_o    (btn_s)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             long_done_q, long_done_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntOne;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (btn_s) begin
          state_d = StDbPress;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      StDbPress: begin
        if (!btn_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DbLast) begin
          state_d = StHeld;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end
      end
      StHeld: begin
        if (!btn_s) begin
          state_d = StDbRelease;
          cnt_d   = CntOne;
        end else if (cnt_q == LongLast) begin
          state_d     = StRepeat;
          long_d      = 1'b1;
          long_done_d = 1'b1;
          cnt_d       = '0;
        end
      end
      StRepeat: begin
        if (!btn_s) begin
          state_d = StDbRelease;
          cnt_d   = CntOne;
        end else if (cnt_q == RepeatLast) begin
          cnt_d    = '0;
          repeat_d = REPEAT_EN;
        end
      end
      StDbRelease: begin
        if (btn_s) begin
          // Bounce during release: resume where we were, no new press event.
          state_d = long_done_q ? StRepeat : StHeld;
          cnt_d   = '0;
        end else if (cnt_q == DbLast) begin
          state_d     = StIdle;
          level_d     = 1'b0;
          release_d   = 1'b1;
          long_done_d = 1'b0;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule
